// File: rtl/dbc_pkg.sv
// Shared encodings and lane helpers for the data-bus controller.
package dbc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_ERR} state_t;
  typedef enum logic [1:0] {TGT_RAM, TGT_GPIO, TGT_REG, TGT_NONE} tgt_t;

  localparam logic [31:0] REG_STATUS_OFF = 32'd0;
  localparam logic [31:0] REG_FAULT_OFF  = 32'd4;

  localparam int STAT_MISALIGN = 0;
  localparam int STAT_UNMAPPED = 1;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
      SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Only aligned accesses reach here, so a plain byte shift places any size correctly.
  function automatic logic [31:0] lane_shift(input logic [31:0] wdata, input logic [1:0] addr_lo);
    lane_shift = wdata << {addr_lo, 3'b000};
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] addr_lo, input logic uns);
    logic [31:0] sh;
    sh = word >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: load_extend = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/dbc_ram.sv
// Single-port synchronous RAM with byte enables and a registered read port.
module dbc_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Load/store bus controller: byte-lane RAM with wait states, GPIO channels and fault status.
// state | meaning
// IDLE  | ready for a request
// WAIT  | RAM wait-state countdown
// RESP  | good response strobe; RAM store commits on exit
// ERR   | fault response strobe
module data_bus_ctrl import dbc_pkg::*; #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter int          RAM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] GPIO_BASE   = 32'h8000_0000,
  parameter int          N_GPIO      = 2,
  parameter logic [31:0] REG_BASE    = 32'h8000_1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  irq_fault,
  output logic [32*N_GPIO-1:0]  gpio_out,
  input  logic [32*N_GPIO-1:0]  gpio_in
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] GPIO_SPAN = 32'(N_GPIO * 4);
  localparam logic [31:0] STAT_ADDR = REG_BASE + REG_STATUS_OFF;
  localparam logic [31:0] FA_ADDR   = REG_BASE + REG_FAULT_OFF;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t        state, state_nxt;
  tgt_t          lat_tgt;
  logic [3:0]    wait_cnt;
  logic          lat_we, lat_uns;
  logic [1:0]    lat_size, lat_lo;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata, rd_q, fault_addr, ram_rdata;
  logic [1:0]    status, status_nxt, stat_set, stat_clr;

  logic [31:0] ram_off, gpio_off, gpio_rd;
  logic [2:0]  gpio_ch;
  logic        accept, ram_hit, gpio_hit, stat_hit, fa_hit, reg_hit;
  logic        size_mis, mis, unmapped, fault;

  assign accept   = req_valid && (state == ST_IDLE);
  assign ram_off  = req_addr - RAM_BASE;
  assign gpio_off = req_addr - GPIO_BASE;
  assign gpio_ch  = gpio_off[4:2];
  assign ram_hit  = (req_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
  assign gpio_hit = (req_addr >= GPIO_BASE) && (gpio_off < GPIO_SPAN);
  assign stat_hit = req_addr[31:2] == STAT_ADDR[31:2];
  assign fa_hit   = req_addr[31:2] == FA_ADDR[31:2];
  assign reg_hit  = stat_hit || fa_hit;
  assign size_mis = (req_size == SZ_ILL) ||
                    ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign mis      = size_mis || ((gpio_hit || reg_hit) && (req_size != SZ_WORD));
  assign unmapped = !(ram_hit || gpio_hit || reg_hit);
  assign fault    = mis || unmapped;

  always_comb begin
    gpio_rd = '0;
    for (int i = 0; i < N_GPIO; i++) begin
      if (gpio_ch == 3'(i)) gpio_rd = gpio_in[32*i +: 32];
    end
  end

  // A new fault overrides a write-1-to-clear landing on the same edge.
  always_comb begin
    stat_set = '0;
    stat_clr = '0;
    if (accept && fault) begin
      stat_set[STAT_MISALIGN] = mis;
      stat_set[STAT_UNMAPPED] = !mis;
    end
    if (accept && !fault && stat_hit && req_we) stat_clr = req_wdata[1:0];
    status_nxt = (status & ~stat_clr) | stat_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) begin
        if (fault)                        state_nxt = ST_ERR;
        else if (ram_hit && WAIT_STATES > 0) state_nxt = ST_WAIT;
        else                              state_nxt = ST_RESP;
      end
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_tgt    <= TGT_NONE;
      lat_we     <= 1'b0;
      lat_uns    <= 1'b0;
      lat_size   <= SZ_BYTE;
      lat_lo     <= 2'b00;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      rd_q       <= '0;
      wait_cnt   <= '0;
      status     <= '0;
      fault_addr <= '0;
      gpio_out   <= '0;
    end else begin
      status <= status_nxt;
      if (accept) begin
        lat_tgt   <= fault ? TGT_NONE : ram_hit ? TGT_RAM : gpio_hit ? TGT_GPIO : TGT_REG;
        lat_we    <= req_we;
        lat_uns   <= req_unsigned;
        lat_size  <= req_size;
        lat_lo    <= req_addr[1:0];
        lat_idx   <= ram_off[AW+1:2];
        lat_wdata <= req_wdata;
        wait_cnt  <= WAIT_INIT;
        rd_q      <= stat_hit ? {30'b0, status} : fa_hit ? fault_addr : gpio_rd;
        if (fault) fault_addr <= req_addr;
        if (!fault && gpio_hit && req_we) begin
          for (int i = 0; i < N_GPIO; i++) begin
            if (gpio_ch == 3'(i)) gpio_out[32*i +: 32] <= req_wdata;
          end
        end
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  dbc_ram #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .addr  ((state == ST_IDLE) ? ram_off[AW+1:2] : lat_idx),
    .we    ((state == ST_RESP) && lat_we && (lat_tgt == TGT_RAM)),
    .be    (lane_mask(lat_size, lat_lo)),
    .wdata (lane_shift(lat_wdata, lat_lo)),
    .rdata (ram_rdata)
  );

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    rsp_valid = (state == ST_RESP) || (state == ST_ERR);
    rsp_err   = (state == ST_ERR);
    irq_fault = |status;
    rsp_rdata = '0;
    if (state == ST_RESP && !lat_we) begin
      rsp_rdata = (lat_tgt == TGT_RAM) ? load_extend(ram_rdata, lat_size, lat_lo, lat_uns) : rd_q;
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed plus random bench for data_bus_ctrl against a byte-level memory-map model.
module tb_data_bus_ctrl;

  localparam int          WS = 3;
  localparam int          NG = 2;
  localparam logic [31:0] GB = 32'h8000_0000;
  localparam logic [31:0] RB = 32'h8000_1000;

  logic          clk, rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_err, busy, irq_fault;
  logic [31:0]   rsp_rdata;
  logic [32*NG-1:0] gpio_out, gpio_in;

  logic [7:0]  m_ram [64];
  logic [31:0] m_gout [NG];
  logic [31:0] gin [NG];
  logic [1:0]  m_status;
  logic [31:0] m_fault_addr;
  int n_vec, n_err;

  assign gpio_in = {gin[1], gin[0]};

  data_bus_ctrl #(.WAIT_STATES(WS), .N_GPIO(NG)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .irq_fault(irq_fault), .gpio_out(gpio_out), .gpio_in(gpio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_gpio();
    chk("gpio_out0", gpio_out[31:0], m_gout[0]);
    chk("gpio_out1", gpio_out[63:32], m_gout[1]);
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic is_ram, is_gpio, is_reg, mis, fault;
    logic [31:0] exp_rd;
    int nb, exp_lat, lat, ch;
    is_ram  = addr < 32'd4096;
    is_gpio = (addr >= GB) && (addr < GB + 32'(4*NG));
    is_reg  = (addr >= RB) && (addr < RB + 32'd8);
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0) ||
          ((is_gpio || is_reg) && size != 2'd2);
    fault = mis || !(is_ram || is_gpio || is_reg);
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_rd = 32'd0;
    exp_lat = 1;
    if (fault) begin
      if (mis) m_status[0] = 1'b1;
      else     m_status[1] = 1'b1;
      m_fault_addr = addr;
    end else if (is_ram) begin
      exp_lat = 1 + WS;
      for (int i = 0; i < nb; i++) begin
        if (we) m_ram[int'(addr) + i] = wdata[8*i +: 8];
        else    exp_rd = exp_rd | (32'(m_ram[int'(addr) + i]) << (8*i));
      end
      if (!we && !uns && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*nb));
    end else if (is_gpio) begin
      ch = int'((addr - GB) >> 2);
      if (we) m_gout[ch] = wdata;
      else    exp_rd = gin[ch];
    end else if (addr == RB) begin
      if (we) m_status = m_status & ~wdata[1:0];
      else    exp_rd = {30'd0, m_status};
    end else if (!we) begin
      exp_rd = m_fault_addr;
    end

    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_err", 32'(rsp_err), 32'(fault));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("irq_fault", 32'(irq_fault), 32'(|m_status));
    check_gpio();
  endtask

  initial begin
    logic [31:0] a;
    int r;
    n_vec = 0; n_err = 0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    gin[0] = 32'h0BAD_0000; gin[1] = 32'h0BAD_0001;
    m_status = '0; m_fault_addr = '0; m_gout[0] = '0; m_gout[1] = '0;
    for (int i = 0; i < 64; i++) m_ram[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq_fault), 32'd0);
    check_gpio();
    rst = 1'b1;

    for (int i = 0; i < 16; i++) access(1'b1, 2'd2, 1'b0, 32'(4*i), 32'd0);
    access(1'b1, 2'd2, 1'b0, GB + 32'd4, 32'h0000_0055);
    access(1'b0, 2'd2, 1'b0, 32'h4000_0000, 32'd0);

    // Reset two cycles into the wait period of a RAM store: no response, store dropped.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'd0; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_ready", 32'(req_ready), 32'd1);
    m_status = '0; m_fault_addr = '0; m_gout[0] = '0; m_gout[1] = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b1;
    access(1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
    access(1'b0, 2'd2, 1'b0, RB, 32'd0);

    access(1'b1, 2'd2, 1'b0, 32'd4, 32'hDEAD_BEEF);
    access(1'b1, 2'd0, 1'b0, 32'd6, 32'h0000_0011);
    access(1'b0, 2'd2, 1'b0, 32'd4, 32'd0);
    chk("plan_word", rsp_rdata, 32'hDE11_BEEF);
    access(1'b0, 2'd0, 1'b0, 32'd7, 32'd0);
    chk("plan_sbyte", rsp_rdata, 32'hFFFF_FFDE);
    access(1'b0, 2'd0, 1'b1, 32'd7, 32'd0);
    chk("plan_ubyte", rsp_rdata, 32'h0000_00DE);
    access(1'b0, 2'd1, 1'b0, 32'd6, 32'd0);
    chk("plan_shalf", rsp_rdata, 32'hFFFF_DE11);

    access(1'b0, 2'd2, 1'b0, 32'd2, 32'd0);
    access(1'b0, 2'd2, 1'b0, RB, 32'd0);
    chk("plan_status_mis", rsp_rdata, 32'h1);
    access(1'b0, 2'd2, 1'b0, RB + 32'd4, 32'd0);
    chk("plan_fault_addr", rsp_rdata, 32'd2);
    access(1'b1, 2'd2, 1'b0, RB, 32'h1);
    access(1'b0, 2'd2, 1'b0, RB, 32'd0);

    access(1'b0, 2'd2, 1'b0, 32'h4000_0000, 32'd0);
    access(1'b1, 2'd0, 1'b0, RB, 32'h3);
    access(1'b0, 2'd2, 1'b0, RB, 32'd0);
    chk("plan_status_both", rsp_rdata, 32'h3);

    gin[1] = 32'hA5A5_0001;
    access(1'b1, 2'd2, 1'b0, GB, 32'h0000_1234);
    access(1'b0, 2'd2, 1'b0, GB + 32'd4, 32'd0);
    chk("plan_gpio_in", rsp_rdata, 32'hA5A5_0001);

    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      a = 32'($urandom_range(0, 63));
      else if (r <= 7) a = GB + 32'($urandom_range(0, 11));
      else if (r == 8) a = RB + 32'($urandom_range(0, 11));
      else             a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
      if ($urandom_range(0, 7) == 0) gin[$urandom_range(0, 1)] = $urandom;
      access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
